// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, opcodes and fetch FSM state type
package pipe_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_target.sv
// rtl/fetch_target.sv - combinational branch/jump target from the IF/ID register
module fetch_target
  import pipe_pkg::*;
(
  input  logic [31:0] ID_INS,
  input  logic [31:0] ID_PC4,
  input  logic        jORb,
  output logic [31:0] target
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        unused_opcode;

  // Branch offset is a signed word count relative to PC+4; wraps at 32 bits
  assign branch_target = ID_PC4 + {{14{ID_INS[15]}}, ID_INS[15:0], 2'b00};
  // Jump stays inside the current 256 MB region
  assign jump_target   = {ID_PC4[31:28], ID_INS[25:0], 2'b00};
  assign target        = jORb ? branch_target : jump_target;

  // Opcode field is decoded by the control unit, not here
  assign unused_opcode = ^ID_INS[31:26];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM, PC and IF/ID register; FETCH_PERF_EN adds stall/flush counters
module instr_fetch_unit
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pcWrite,
  input  logic        ifidWrite,
  input  logic        ifidFlush,
  input  logic        pcSrc,
  input  logic        jORb,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_INS,
  output logic [31:0] ID_PC4,
  output logic        ID_valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  drain_addr;
  logic [31:0]  hold_buf;
  logic [31:0]  target;
  logic         load_ifid;
  logic [31:0]  load_word;

  fetch_target u_target (
    .ID_INS (ID_INS),
    .ID_PC4 (ID_PC4),
    .jORb   (jORb),
    .target (target)
  );

  // The request stays up in DRAIN so the abandoned access completes on the
  // address memory already saw; the new PC is presented only afterwards.
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  // Select whether this edge moves a fresh or held word into IF/ID
  always_comb begin
    load_ifid = 1'b0;
    load_word = imem_rdata;
    case (state)
      REQ: begin
        if (!pcSrc && imem_ack && ifidWrite) begin
          load_ifid = 1'b1;
        end
      end
      HOLD: begin
        if (!pcSrc && ifidWrite) begin
          load_ifid = 1'b1;
          load_word = hold_buf;
        end
      end
      default: begin
        load_ifid = 1'b0;
      end
    endcase
  end

  // Fetch FSM: PC sequencing, hold buffer capture and redirect draining
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      hold_buf   <= NOP;
    end else begin
      case (state)
        REQ: begin
          if (pcSrc) begin
            pc <= target;
            if (!imem_ack) begin
              drain_addr <= pc;
              state      <= DRAIN;
            end
          end else if (imem_ack) begin
            if (ifidWrite) begin
              if (pcWrite) begin
                pc <= pc + 32'd4;
              end
            end else begin
              hold_buf <= imem_rdata;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (pcSrc) begin
            pc    <= target;
            state <= REQ;
          end else if (ifidWrite) begin
            if (pcWrite) begin
              pc <= pc + 32'd4;
            end
            state <= REQ;
          end
        end
        DRAIN: begin
          if (pcSrc) begin
            pc <= target;
          end
          if (imem_ack) begin
            state <= REQ;
          end
        end
        default: begin
          state <= REQ;
        end
      endcase
    end
  end

  // IF/ID register: flush beats any load and leaves PC+4 untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      ID_INS   <= NOP;
      ID_PC4   <= RESET_PC;
      ID_valid <= 1'b0;
    end else if (ifidFlush) begin
      ID_INS   <= NOP;
      ID_valid <= 1'b0;
    end else if (load_ifid) begin
      ID_INS   <= load_word;
      ID_PC4   <= pc + 32'd4;
      ID_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  logic        discard;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  assign discard = (pcSrc && ((state == REQ && imem_ack) || state == HOLD)) ||
                   (state == DRAIN && imem_ack);

  // Free-running performance counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (!pcWrite || state == HOLD) begin
        stall_q <= stall_q + 32'd1;
      end
      if (ifidFlush || discard) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with a reference model
module tb_instr_fetch_unit;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcWrite;
  logic        ifidWrite;
  logic        ifidFlush;
  logic        pcSrc;
  logic        jORb;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ID_INS;
  logic [31:0] ID_PC4;
  logic        ID_valid;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic [31:0] ft_ins;
  logic [31:0] ft_pc4;
  logic        ft_jorb;
  logic [31:0] ft_target;

  int errors = 0;
  int checks = 0;
  int lat = 0;
  int wait_cnt = 0;
  bit started = 1'b0;

  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_drain;
  logic [31:0] m_drain_addr;
  logic [31:0] m_stall;
  logic [31:0] m_flush;
  logic [31:0] m_hold_q[$];

  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic        exp_req;
  logic [31:0] exp_stall;
  logic [31:0] exp_flush;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pcWrite    (pcWrite),
    .ifidWrite  (ifidWrite),
    .ifidFlush  (ifidFlush),
    .pcSrc      (pcSrc),
    .jORb       (jORb),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ID_INS     (ID_INS),
    .ID_PC4     (ID_PC4),
    .ID_valid   (ID_valid),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  fetch_target u_ft (
    .ID_INS (ft_ins),
    .ID_PC4 (ft_pc4),
    .jORb   (ft_jorb),
    .target (ft_target)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_000C: return {BEQ, 5'd1, 5'd2, 16'h0003};
      32'h0000_001C: return {J, 26'h000_0040};
      32'h0000_0100: return {BNE, 5'd3, 5'd4, 16'hFFFC};
      default:       return 32'hC000_0000 | a;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] ins, input logic [31:0] pc4,
                                               input logic jb);
    int off;
    if (jb) begin
      off = int'($signed(ins[15:0]));
      return pc4 + 32'(off * 4);
    end
    return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
  endfunction

  // Reference behaviour: a held word is a queue entry, a pending squash is m_drain
  task automatic model_update();
    logic [31:0] npc;
    logic [31:0] w;
    logic [31:0] tgt;
    logic        ld;
    logic        disc;
    if (rst) begin
      m_pc = 32'd0; m_ins = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      m_hold_q.delete(); m_drain = 1'b0; m_drain_addr = 32'd0;
      m_stall = 32'd0; m_flush = 32'd0;
      return;
    end
    npc = m_pc; w = 32'd0; ld = 1'b0; disc = 1'b0;
    tgt = model_target(m_ins, m_pc4, jORb);
    if (!pcWrite || m_hold_q.size() != 0) m_stall = m_stall + 32'd1;
    if (m_hold_q.size() != 0) begin
      if (pcSrc) begin
        m_hold_q.delete(); npc = tgt; disc = 1'b1;
      end else if (ifidWrite) begin
        w = m_hold_q.pop_front(); ld = 1'b1;
        if (pcWrite) npc = m_pc + 32'd4;
      end
    end else if (m_drain) begin
      if (pcSrc) npc = tgt;
      if (imem_ack) begin
        m_drain = 1'b0; disc = 1'b1;
      end
    end else begin
      if (pcSrc) begin
        npc = tgt;
        if (imem_ack) disc = 1'b1;
        else begin
          m_drain = 1'b1; m_drain_addr = m_pc;
        end
      end else if (imem_ack) begin
        if (ifidWrite) begin
          w = imem_rdata; ld = 1'b1;
          if (pcWrite) npc = m_pc + 32'd4;
        end else begin
          m_hold_q.push_back(imem_rdata);
        end
      end
    end
    if (ifidFlush || disc) m_flush = m_flush + 32'd1;
    if (ifidFlush) begin
      m_ins = 32'd0; m_valid = 1'b0;
    end else if (ld) begin
      m_ins = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end
    m_pc = npc;
  endtask

  // Memory responder: ack after lat wait cycles, garbage data when not acking
  task automatic mem_respond();
    #1;
    if (rst || !imem_req) begin
      imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; wait_cnt = 0;
    end else if (wait_cnt >= lat) begin
      imem_ack = 1'b1; imem_rdata = memf(imem_addr); wait_cnt = 0;
    end else begin
      imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; wait_cnt++;
    end
  endtask

  task automatic cycle();
    mem_respond();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (started) begin
      exp_req = !rst && (m_hold_q.size() == 0);
`ifdef FETCH_PERF_EN
      exp_stall = m_stall;
      exp_flush = m_flush;
`else
      exp_stall = 32'd0;
      exp_flush = 32'd0;
`endif
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, m_drain ? m_drain_addr : m_pc);
      chk("ID_INS", ID_INS, m_ins);
      chk("ID_PC4", ID_PC4, m_pc4);
      chk("ID_valid", 32'(ID_valid), 32'(m_valid));
      chk("stall_cnt", stall_cnt, exp_stall);
      chk("flush_cnt", flush_cnt, exp_flush);
      if (prev_req && !prev_ack) chk("addr_stable", imem_addr, prev_addr);
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  logic [1:0]  pat    [12] = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11,
                               2'b00, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11};
  logic [31:0] ft_i   [5]  = '{32'h0000_0040, 32'h1022_0003, 32'h1000_8000,
                               32'h1000_7FFF, 32'hFFFF_FFFF};
  logic [31:0] ft_p   [5]  = '{32'h4000_0008, 32'h0000_0010, 32'h0001_0000,
                               32'hFFFF_FFF0, 32'hA000_0000};
  logic        ft_j   [5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] ft_exp [5]  = '{32'h4000_0100, 32'h0000_001C, 32'hFFFF_0000,
                               32'h0001_FFEC, 32'hAFFF_FFFC};

  initial begin
    rst = 1'b1; pcWrite = 1'b1; ifidWrite = 1'b1; ifidFlush = 1'b0;
    pcSrc = 1'b0; jORb = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    ft_ins = 32'd0; ft_pc4 = 32'd0; ft_jorb = 1'b0;

    cycle(); cycle();
    started = 1'b1;
    chk("rst_ID_INS", ID_INS, 32'h0);
    chk("rst_ID_valid", 32'(ID_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    rst = 1'b0;

    cycle();
    chk("z0_ID_INS", ID_INS, 32'h2001_0005);
    chk("z0_ID_PC4", ID_PC4, 32'h4);
    chk("z0_pc", imem_addr, 32'h4);
    cycle(); cycle();

    pcWrite = 1'b0; ifidWrite = 1'b0;
    repeat (3) cycle();
    chk("hold_ID_INS", ID_INS, 32'hC000_0008);
    chk("hold_req", 32'(imem_req), 32'h0);
`ifdef FETCH_PERF_EN
    chk("hold_stall", stall_cnt, 32'd3);
`else
    chk("hold_stall", stall_cnt, 32'd0);
`endif
    pcWrite = 1'b1; ifidWrite = 1'b1;
    cycle();
    chk("rel_ID_INS", ID_INS, 32'h1022_0003);
    chk("rel_ID_PC4", ID_PC4, 32'h10);

    pcSrc = 1'b1; jORb = 1'b1; ifidFlush = 1'b1;
    cycle();
    chk("br_addr", imem_addr, 32'h1C);
    chk("br_ID_INS", ID_INS, 32'h0);
    chk("br_valid", 32'(ID_valid), 32'h0);
    chk("br_ID_PC4", ID_PC4, 32'h10);
    pcSrc = 1'b0; jORb = 1'b0; ifidFlush = 1'b0;
    cycle();
    chk("j_ID_INS", ID_INS, 32'h0800_0040);
    chk("j_ID_PC4", ID_PC4, 32'h20);

    lat = 2; pcSrc = 1'b1; jORb = 1'b0; ifidFlush = 1'b1;
    cycle();
    chk("dr_req", 32'(imem_req), 32'h1);
    chk("dr_addr", imem_addr, 32'h20);
    pcSrc = 1'b0; ifidFlush = 1'b0;
    cycle();
    chk("dr_addr2", imem_addr, 32'h20);
    cycle();
    chk("dr_new_addr", imem_addr, 32'h100);
    chk("dr_valid", 32'(ID_valid), 32'h0);
`ifdef FETCH_PERF_EN
    chk("dr_flush", flush_cnt, 32'd3);
`else
    chk("dr_flush", flush_cnt, 32'd0);
`endif
    cycle(); cycle();
    chk("dr_lat_valid", 32'(ID_valid), 32'h0);
    cycle();
    chk("dr_ID_INS", ID_INS, 32'h1464_FFFC);
    chk("dr_ID_PC4", ID_PC4, 32'h104);

    lat = 0; ifidWrite = 1'b0;
    cycle();
    pcSrc = 1'b1; jORb = 1'b1;
    cycle();
    chk("hb_addr", imem_addr, 32'hF4);
    chk("hb_ID_INS", ID_INS, 32'h1464_FFFC);
    pcSrc = 1'b0; jORb = 1'b0; ifidWrite = 1'b1;
    cycle();
    chk("hb_ID_PC4", ID_PC4, 32'hF8);

    ifidWrite = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rh_addr", imem_addr, 32'h0);
    chk("rh_valid", 32'(ID_valid), 32'h0);
    chk("rh_req", 32'(imem_req), 32'h0);
    chk("rh_stall", stall_cnt, 32'h0);
    chk("rh_flush", flush_cnt, 32'h0);
    rst = 1'b0; ifidWrite = 1'b1;
    #1;
    chk("rh_req_after", 32'(imem_req), 32'h1);
    cycle();
    chk("rh_ID_INS", ID_INS, 32'h2001_0005);

    lat = 1;
    for (int i = 0; i < 12; i++) begin
      {pcWrite, ifidWrite} = pat[i];
      cycle();
    end
    pcWrite = 1'b1; ifidWrite = 1'b1;
    repeat (4) cycle();

    for (int i = 0; i < 5; i++) begin
      ft_ins = ft_i[i]; ft_pc4 = ft_p[i]; ft_jorb = ft_j[i];
      #1;
      chk($sformatf("ft_dut_%0d", i), ft_target, ft_exp[i]);
      chk($sformatf("ft_model_%0d", i), model_target(ft_i[i], ft_p[i], ft_j[i]), ft_exp[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port pcWrite, input, 1, PC update enable from CU (0 = load-use stall).
REQ-004 SHALL have port ifidWrite, input, 1, IF/ID register update enable from CU.
REQ-005 SHALL have port ifidFlush, input, 1, replace the IF/ID contents with NOP on the next edge.
REQ-006 SHALL have port pcSrc, input, 1, redirect PC to the computed target.
REQ-007 SHALL have port jORb, input, 1, target select: 1 = branch, 0 = jump.
REQ-008 SHALL have port imem_req, output, 1, instruction memory request.
REQ-009 SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-010 SHALL have port imem_ack, input, 1, rdata valid this cycle (latency 1..N cycles).
REQ-011 SHALL have port imem_rdata, input, 32, fetched instruction.
REQ-012 SHALL have port ID_INS, output, 32, IF/ID instruction, fed to CU INS.
REQ-013 SHALL have port ID_PC4, output, 32, IF/ID PC+4.
REQ-014 SHALL have port ID_valid, output, 1, 1 = ID_INS is a real fetched instruction.
REQ-015 SHALL have ports stall_cnt and flush_cnt, output, 32 each, performance counters (see Configuration).

Function
REQ-016 SHALL compute branch target = ID_PC4 + (sign-extended ID_INS[15:0] << 2) and jump target = {ID_PC4[31:28], ID_INS[25:0], 2'b00}; 32-bit wrap, no overflow detection.
REQ-017 SHALL implement FSM states REQ, HOLD, DRAIN.
REQ-018 In REQ: imem_req=1 and imem_addr=PC; on imem_ack with ifidWrite=1, load the IF/ID register with {rdata, PC+4}, set ID_valid=1, and set PC=PC+4 if pcWrite=1.
REQ-019 On imem_ack with ifidWrite=0: latch rdata into a 1-entry hold buffer and go to HOLD; imem_req=0 in HOLD.
REQ-020 In HOLD: when ifidWrite=1, load IF/ID from the hold buffer, advance PC if pcWrite=1, and return to REQ.
REQ-021 When pcSrc=1: PC is set to the target on that edge regardless of pcWrite, and pcSrc takes priority over PC+4.
REQ-022 pcSrc=1 in REQ without imem_ack: go to DRAIN; in DRAIN hold imem_req=1 with the old address until imem_ack, discard the data, then go to REQ at the new PC.
REQ-023 pcSrc=1 in REQ with imem_ack, or in HOLD: the fetched or held data is discarded, and the FSM goes to or stays in REQ.
REQ-024 ifidFlush=1 SHALL force ID_INS=32'h0, ID_valid=0, and ID_PC4 unchanged on the next edge; this overrides ifidWrite and any concurrent load.
REQ-025 ifidWrite=0 without flush: the IF/ID register holds its value.
REQ-026 Latency: after redirect, the first target instruction appears in ID_INS no earlier than imem latency+1 cycles later.
REQ-027 imem_addr SHALL change only when imem_req=0 or in the same cycle that imem_ack is received.

Reset
REQ-028 On rst=1 at an edge: PC=RESET_PC (32'h0), state=REQ, ID_INS=0, ID_PC4=0, ID_valid=0, hold buffer=0, counters=0.
REQ-029 Reset mid-request: any in-flight ack after reset is not squashed; memory is reset together with this unit.
REQ-030 imem_req SHALL be 0 while rst=1.

Configuration
REQ-031 Macro FETCH_PERF_EN: when defined, stall_cnt counts cycles with pcWrite=0 or state=HOLD, and flush_cnt counts edges with ifidFlush=1 or a discard (REQ-022/023); both counters wrap at 2^32.
REQ-032 When FETCH_PERF_EN is undefined, stall_cnt and flush_cnt SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-033 Package pipe_pkg SHALL hold RESET_PC, NOP (32'h0), the opcode constants (R_TYPE, LW, SW, J, BEQ, BNE), and the fetch FSM state type.
REQ-034 Target calculation SHALL be the combinational sub-module fetch_target (inputs ID_INS, ID_PC4, jORb; output target).

Verification
REQ-035 Zero-wait imem returning 0x20010005 at PC 0: ID_INS=0x20010005 and ID_PC4=4 one cycle after ack, with PC then 4.
REQ-036 ifidWrite=0 and pcWrite=0 for 3 cycles while ack arrives: FSM in HOLD, ID_INS unchanged, imem_req=0; release -> held word appears next edge; stall_cnt=3 (FETCH_PERF_EN).
REQ-037 ID_INS=BEQ offset 0x0003, ID_PC4=0x10, pcSrc=jORb=1: next imem_addr=0x1C; ifidFlush=1 -> ID_INS=0, ID_valid=0.
REQ-038 Jump with ID_INS[25:0]=0x0000040 and ID_PC4=0x40000008: next imem_addr=0x40000100.
REQ-039 3-cycle imem latency with pcSrc=1 in cycle 1 of the request: old data discarded in DRAIN, new target is requested after the ack, and flush_cnt increments.
REQ-040 rst asserted during HOLD: next cycle state=REQ, imem_addr=0, ID_valid=0, and counters are 0.
